// File: rtl/digital_signal_pkg.sv
// Shared definitions for the digital signal generator.
//   gen_state_t   : FSM state encoding (IDLE, HIGH, LOW, FINISH)
//   CNT_W_DEFAULT : default width of every cycle/count field
package digital_signal_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_FINISH = 2'd3
    } gen_state_t;

endpackage

// File: rtl/sig_phase_counter.sv
// Phase length down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over en)
//   load_val   : N-1 for an N-cycle phase
//   en         : count down by one per cycle while nonzero
//   terminal   : counter is at 0, i.e. current cycle is the last of the phase
module sig_phase_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         terminal
);

    logic [W-1:0] cnt_reg;

    // Loading N-1 and stopping at 0 gives exactly N cycles, including
    // N = 2^W-1, without ever needing a W+1-bit value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign terminal = (cnt_reg == '0);

endmodule

// File: rtl/digital_signal_gen.sv
// Programmable pulse-train generator.
//   clk, rst_n   : clock, asynchronous active-low reset
//   gen_start    : start request, honoured only in IDLE
//   gen_stop     : graceful stop; the running period always completes
//   high_cycles  : high phase length (sampled at start and period boundaries)
//   low_cycles   : low phase length (sampled at start and period boundaries)
//   pulse_count  : number of periods to emit, 0 = continuous (sampled at start)
//   gen_pin      : generated waveform (registered)
//   busy         : state is HIGH or LOW
//   period_done  : asserted during the last LOW cycle of every period
//   gen_done     : asserted during the single FINISH cycle
//   cfg_err      : one-cycle pulse after a start/reconfiguration is rejected
//   periods_sent : completed periods of the current or last run
module digital_signal_gen
    import digital_signal_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gen_start,
    input  logic             gen_stop,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [CNT_W-1:0] pulse_count,
    output logic             gen_pin,
    output logic             busy,
    output logic             period_done,
    output logic             gen_done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] periods_sent
);

    gen_state_t       state_reg, state_next;
    logic [CNT_W-1:0] low_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] periods_sent_reg;
    logic [CNT_W-1:0] sent_plus1;
    logic             stop_pending_reg;
    logic             gen_pin_reg;
    logic             cfg_err_reg;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_term;

    logic             latch_cfg;
    logic             latch_count;
    logic             sent_clear;
    logic             sent_inc;
    logic             cfg_err_next;
    logic             cfg_ok;
    logic             count_hit;
    logic             stop_now;
    logic             running;

    sig_phase_counter #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .terminal (cnt_term)
    );

    assign running    = (state_reg == ST_HIGH) || (state_reg == ST_LOW);
    assign cfg_ok     = (high_cycles != '0) && (low_cycles != '0);
    assign sent_plus1 = periods_sent_reg + 1'b1;
    assign count_hit  = (count_reg != '0) && (sent_plus1 == count_reg);
    // A stop arriving on the very last LOW cycle still ends the run there.
    assign stop_now   = stop_pending_reg || gen_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        latch_cfg    = 1'b0;
        latch_count  = 1'b0;
        sent_clear   = 1'b0;
        sent_inc     = 1'b0;
        cfg_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (gen_start && !gen_stop) begin
                    if (cfg_ok) begin
                        state_next   = ST_HIGH;
                        cnt_load     = 1'b1;
                        cnt_load_val = high_cycles - 1'b1;
                        latch_cfg    = 1'b1;
                        latch_count  = 1'b1;
                        sent_clear   = 1'b1;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                cnt_en = 1'b1;
                if (cnt_term) begin
                    state_next   = ST_LOW;
                    cnt_load     = 1'b1;
                    cnt_load_val = low_reg - 1'b1;
                end
            end
            ST_LOW: begin
                cnt_en = 1'b1;
                if (cnt_term) begin
                    sent_inc = 1'b1;
                    if (count_hit || stop_now) begin
                        state_next = ST_FINISH;
                    end else if (!cfg_ok) begin
                        state_next   = ST_FINISH;
                        cfg_err_next = 1'b1;
                    end else begin
                        // Period boundary: new phase lengths take effect here.
                        state_next   = ST_HIGH;
                        cnt_load     = 1'b1;
                        cnt_load_val = high_cycles - 1'b1;
                        latch_cfg    = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The high length lives only in the phase counter once loaded; the low
    // length must be held until the HIGH phase ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_reg          <= '0;
            count_reg        <= '0;
            periods_sent_reg <= '0;
            stop_pending_reg <= 1'b0;
            gen_pin_reg      <= 1'b0;
            cfg_err_reg      <= 1'b0;
        end else begin
            if (latch_cfg) begin
                low_reg <= low_cycles;
            end
            if (latch_count) begin
                count_reg <= pulse_count;
            end
            if (sent_clear) begin
                periods_sent_reg <= '0;
            end else if (sent_inc) begin
                periods_sent_reg <= sent_plus1;
            end
            stop_pending_reg <= running ? (stop_pending_reg || gen_stop) : 1'b0;
            gen_pin_reg      <= (state_next == ST_HIGH);
            cfg_err_reg      <= cfg_err_next;
        end
    end

    assign gen_pin      = gen_pin_reg;
    assign busy         = running;
    assign period_done  = (state_reg == ST_LOW) && cnt_term;
    assign gen_done     = (state_reg == ST_FINISH);
    assign cfg_err      = cfg_err_reg;
    assign periods_sent = periods_sent_reg;

endmodule

// File: tb/tb_digital_signal_gen.sv
module tb_digital_signal_gen;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         gen_start;
    logic         gen_stop;
    logic [W-1:0] high_cycles;
    logic [W-1:0] low_cycles;
    logic [W-1:0] pulse_count;
    logic         gen_pin;
    logic         busy;
    logic         period_done;
    logic         gen_done;
    logic         cfg_err;
    logic [W-1:0] periods_sent;

    int pass_cnt  = 0;
    int total_cnt = 0;

    digital_signal_gen #(.CNT_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gen_start    (gen_start),
        .gen_stop     (gen_stop),
        .high_cycles  (high_cycles),
        .low_cycles   (low_cycles),
        .pulse_count  (pulse_count),
        .gen_pin      (gen_pin),
        .busy         (busy),
        .period_done  (period_done),
        .gen_done     (gen_done),
        .cfg_err      (cfg_err),
        .periods_sent (periods_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accepting edge,
    // which is the first cycle gen_pin must be high.
    task automatic start_run(input int h, input int l, input int c);
        high_cycles = W'(h);
        low_cycles  = W'(l);
        pulse_count = W'(c);
        gen_start   = 1'b1;
        @(negedge clk);
        gen_start   = 1'b0;
    endtask

    // Checks nper periods of h high / l low cycles; periods_sent starts at base.
    // With last set, also checks the FINISH cycle and the idle cycle after it.
    task automatic check_wave(input int h, input int l, input int nper, input int base,
                              input bit last, input bit cerr, input string name);
        logic [4:0] exp_v;
        logic [4:0] act_v;
        int per;
        int errs;
        per  = h + l;
        errs = 0;
        for (int p = 0; p < nper; p++) begin
            for (int j = 0; j < per; j++) begin
                exp_v = {(j < h), 1'b1, (j == per - 1), 1'b0, 1'b0};
                act_v = {gen_pin, busy, period_done, gen_done, cfg_err};
                total_cnt++;
                if (act_v !== exp_v || periods_sent !== W'(base + p)) begin
                    if (errs < 8)
                        $display("FAIL %s p%0d c%0d pin/busy/pd/done/err=%b sent=%0d expected %b sent=%0d",
                                 name, p, j, act_v, periods_sent, exp_v, base + p);
                    errs++;
                end else begin
                    pass_cnt++;
                end
                @(negedge clk);
            end
        end
        if (last) begin
            exp_v = {1'b0, 1'b0, 1'b0, 1'b1, cerr};
            act_v = {gen_pin, busy, period_done, gen_done, cfg_err};
            total_cnt++;
            if (act_v !== exp_v || periods_sent !== W'(base + nper))
                $display("FAIL %s finish pin/busy/pd/done/err=%b sent=%0d expected %b sent=%0d",
                         name, act_v, periods_sent, exp_v, base + nper);
            else
                pass_cnt++;
            @(negedge clk);
            act_v = {gen_pin, busy, period_done, gen_done, cfg_err};
            total_cnt++;
            if (act_v !== 5'b0)
                $display("FAIL %s idle pin/busy/pd/done/err=%b expected 00000", name, act_v);
            else
                pass_cnt++;
            @(negedge clk);
        end
        $display("%s: %0d periods of %0d/%0d checked, %0d cycle errors", name, nper, h, l, errs);
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if ({gen_pin, busy, period_done, gen_done, cfg_err} !== 5'b0 || periods_sent !== '0)
            $display("FAIL reset outputs=%b sent=%0d expected 00000 sent=0",
                     {gen_pin, busy, period_done, gen_done, cfg_err}, periods_sent);
        else
            pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs checked in reset");
    endtask

    task automatic test_basic();
        start_run(50, 50, 2);
        check_wave(50, 50, 2, 0, 1'b1, 1'b0, "basic_50_50_x2");
    endtask

    task automatic test_stop();
        bit seen_high;
        start_run(60, 20, 0);
        fork
            check_wave(60, 20, 3, 0, 1'b1, 1'b0, "stop_60_20");
            begin
                repeat (189) @(negedge clk);  // 30th cycle of period 3
                gen_stop = 1'b1;
                @(negedge clk);
                gen_stop = 1'b0;
            end
        join
        seen_high = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (gen_pin !== 1'b0 || busy !== 1'b0) seen_high = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen_high) $display("FAIL stop_no_rise activity after stop, expected none");
        else           pass_cnt++;
    endtask

    task automatic test_min();
        start_run(1, 1, 4);
        check_wave(1, 1, 4, 0, 1'b1, 1'b0, "square_1_1_x4");
    endtask

    task automatic test_cfg_err();
        logic [W-1:0] hv [3] = '{16'd0, 16'd5, 16'd5};
        logic [W-1:0] lv [3] = '{16'd10, 16'd0, 16'd5};
        logic         sv [3] = '{1'b0, 1'b0, 1'b1};
        logic         ev [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            gen_stop = sv[k];
            start_run(int'(hv[k]), int'(lv[k]), 1);
            gen_stop = 1'b0;
            total_cnt++;
            if ({cfg_err, busy, gen_pin} !== {ev[k], 2'b00})
                $display("FAIL cfg_err_%0d err/busy/pin=%b expected %b", k,
                         {cfg_err, busy, gen_pin}, {ev[k], 2'b00});
            else
                pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({cfg_err, busy, gen_pin} !== 3'b000)
                $display("FAIL cfg_err_after_%0d err/busy/pin=%b expected 000", k,
                         {cfg_err, busy, gen_pin});
            else
                pass_cnt++;
            $display("cfg_err case %0d: high=%0d low=%0d stop=%0d", k, hv[k], lv[k], sv[k]);
        end
    endtask

    task automatic test_reconfig();
        start_run(54, 6, 0);
        fork
            check_wave(54, 6, 1, 0, 1'b0, 1'b0, "reconfig_first");
            begin
                repeat (19) @(negedge clk);
                high_cycles = W'(10);
            end
        join
        check_wave(10, 6, 1, 1, 1'b0, 1'b0, "reconfig_second");
        fork
            check_wave(10, 6, 1, 2, 1'b1, 1'b0, "reconfig_stopped");
            begin
                gen_stop = 1'b1;
                @(negedge clk);
                gen_stop = 1'b0;
            end
        join
    endtask

    task automatic test_reconfig_err();
        start_run(3, 2, 0);
        fork
            check_wave(3, 2, 1, 0, 1'b1, 1'b1, "reconfig_zero_high");
            begin
                @(negedge clk);
                high_cycles = '0;
            end
        join
    endtask

    task automatic test_ignore_start();
        start_run(4, 3, 1);
        fork
            check_wave(4, 3, 1, 0, 1'b1, 1'b0, "start_while_busy");
            begin
                @(negedge clk);
                high_cycles = W'(1);
                gen_start   = 1'b1;
                repeat (2) @(negedge clk);
                gen_start   = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid();
        bit bad;
        start_run(30, 30, 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({gen_pin, busy, period_done, gen_done, cfg_err} !== 5'b0)
            $display("FAIL reset_async outputs=%b expected 00000",
                     {gen_pin, busy, period_done, gen_done, cfg_err});
        else
            pass_cnt++;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({gen_pin, busy, period_done, gen_done, cfg_err} !== 5'b0 || periods_sent !== '0)
                bad = 1'b1;
        end
        total_cnt++;
        if (bad) $display("FAIL reset_hold outputs nonzero during reset, expected all 0");
        else     pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({gen_pin, busy, gen_done} !== 3'b000)
            $display("FAIL reset_release pin/busy/done=%b expected 000", {gen_pin, busy, gen_done});
        else
            pass_cnt++;
        start_run(2, 3, 1);
        check_wave(2, 3, 1, 0, 1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        start_run(2, 2, 1);
        check_wave(2, 2, 1, 0, 1'b1, 1'b0, "b2b_first");
        start_run(1, 3, 2);
        check_wave(1, 3, 2, 0, 1'b1, 1'b0, "b2b_second");
    endtask

    initial begin
        rst_n       = 1'b0;
        gen_start   = 1'b0;
        gen_stop    = 1'b0;
        high_cycles = '0;
        low_cycles  = '0;
        pulse_count = '0;
        test_reset();
        test_basic();
        test_stop();
        test_min();
        test_cfg_err();
        test_reconfig();
        test_reconfig_err();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/digital_signal_gen.md
DIGITAL_SIGNAL_GEN -- requirements
Module: digital_signal_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all cycle and count fields.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port gen_start  input  1  level-sampled start request, acted on only in IDLE.
REQ-005 SHALL have port gen_stop  input  1  graceful stop request.
REQ-006 SHALL have port high_cycles  input  CNT_W  high-phase length in clk cycles.
REQ-007 SHALL have port low_cycles  input  CNT_W  low-phase length in clk cycles.
REQ-008 SHALL have port pulse_count  input  CNT_W  periods to emit; 0 = continuous.
REQ-009 SHALL have port gen_pin  output  1  generated signal, registered.
REQ-010 SHALL have port busy  output  1  high while state is HIGH or LOW.
REQ-011 SHALL have port period_done  output  1  one-cycle pulse on the last LOW cycle of each period.
REQ-012 SHALL have port gen_done  output  1  one-cycle pulse when a run ends.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse when start is rejected.
REQ-014 SHALL have port periods_sent  output  CNT_W  completed periods in current/last run.

Function
REQ-015 SHALL implement FSM states IDLE, HIGH, LOW, FINISH.
REQ-016 In IDLE with gen_start=1, gen_stop=0, and nonzero high_cycles and low_cycles, SHALL latch high_cycles, low_cycles, and pulse_count, clear periods_sent, and enter HIGH.
REQ-017 gen_pin SHALL be 1 starting the cycle after the accepting edge; latency start-to-rise is 1 clk.
REQ-018 gen_pin SHALL stay 1 for exactly latched high_cycles clocks, then 0 for exactly latched low_cycles clocks.
REQ-019 On the last LOW cycle, SHALL pulse period_done, increment periods_sent (wrapping at 2^CNT_W-1 to 0), and decide the next state.
REQ-020 Decision: next state SHALL be FINISH if pulse_count!=0 and periods_sent+1==pulse_count, or if a stop is pending; otherwise it SHALL be HIGH.
REQ-021 When returning to HIGH, SHALL re-sample high_cycles and low_cycles (reconfiguration takes effect only at period boundaries); pulse_count is NOT re-sampled.
REQ-022 If re-sampled high_cycles or low_cycles is 0, SHALL pulse cfg_err and go to FINISH instead.
REQ-023 gen_stop SHALL be held pending from assertion in HIGH/LOW until the period ends; the current period always completes, and no truncated pulses are emitted.
REQ-024 FINISH SHALL last one cycle: gen_pin=0, gen_done=1, then IDLE.
REQ-025 gen_start with a zero high_cycles or low_cycles in IDLE SHALL pulse cfg_err, stay in IDLE, and leave gen_pin=0.
REQ-026 gen_start=1 together with gen_stop=1 in IDLE SHALL be ignored (no cfg_err).
REQ-027 gen_start outside IDLE SHALL be ignored.
REQ-028 high_cycles=1, low_cycles=1 SHALL give a 2-clk square wave with no gaps.
REQ-029 Phase counters SHALL be CNT_W-bit down-counters loaded with N-1 and terminal at 0; no off-by-one at the maximum value 2^CNT_W-1.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, gen_pin=0, busy=0, period_done=0, gen_done=0, cfg_err=0, periods_sent=0, all latched config=0, and stop pending=0.
REQ-031 Reset mid-run SHALL NOT produce gen_done or period_done; after release the block sits in IDLE awaiting gen_start.

Structure
REQ-032 The state encoding typedef and the default CNT_W constant SHALL reside in the shared package digital_signal_pkg.
REQ-033 The phase down-counter SHALL be one sub-module, sig_phase_counter (load, enable, terminal flag); the FSM SHALL be the top level.

Verification
REQ-034 high=50, low=50, count=2: gen_pin has 50 high and 50 low clks twice; period_done at clk 100 and 200 after start; periods_sent=2; gen_done one clk later.
REQ-035 high=60, low=20, count=0; gen_stop pulsed at clk 30 of period 3: the period completes to 80 clks, periods_sent=3, gen_done follows, and no further rise occurs.
REQ-036 high=1, low=1, count=4: gen_pin toggles every clk for 8 clks; 4 period_done pulses.
REQ-037 high=0, low=10, gen_start: cfg_err pulses once, busy stays 0, and gen_pin stays 0.
REQ-038 high=54, low=6, count=0; high changed to 10 mid-period: the current period stays 54/6 and the next is 10/6.
REQ-039 rst_n asserted during the HIGH phase: gen_pin drops to 0 without waiting for a clk edge; all outputs are 0 with no done pulse; a new gen_start works normally afterwards.
